// File: rtl/stepper_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : stepper_ctrl_v2
// Purpose  : Two-coil stepper controller for an H-bridge driver. Provides
//            wave/full/half stepping from a synchronised external step input
//            or from a command-driven move engine (step count + period).
//            Tracks a signed position and drops VREF to a hold level after
//            an idle period.
// Ports    : clk, rst_n               clock, async active-low reset
//            i_module_enable          0 = driver off, steps/commands ignored
//            i_step_mode[1:0]         0 wave, 1 full, 2/3 half
//            i_ext_step, i_ext_dir    async step pulse and its direction
//            i_cmd_valid/o_cmd_ready  move request handshake
//            i_cmd_steps, i_cmd_dir   move length and direction
//            i_step_period            clk cycles per step (0 -> 1)
//            i_abort                  stop the current move
//            i_run_level/hold_level   VREF duty when active / idle
//            o_ina1..o_inb2           coil bridge controls
//            o_stanby, o_vref_pwm     driver standby, current reference PWM
//            o_position               signed step position (wraps)
//            o_busy, o_step_strobe    move in progress, 1-cycle step pulse
// Revision : 1.0 - initial release
// ============================================================================
module stepper_ctrl_v2 #(
  parameter int PWM_W       = 4,
  parameter int POS_W       = 16,
  parameter int CNT_W       = 16,
  parameter int DIV_W       = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_module_enable,
  input  logic [1:0]              i_step_mode,
  input  logic                    i_ext_step,
  input  logic                    i_ext_dir,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [CNT_W-1:0]        i_cmd_steps,
  input  logic                    i_cmd_dir,
  input  logic [DIV_W-1:0]        i_step_period,
  input  logic                    i_abort,
  input  logic [PWM_W-1:0]        i_run_level,
  input  logic [PWM_W-1:0]        i_hold_level,
  output logic                    o_ina1,
  output logic                    o_ina2,
  output logic                    o_inb1,
  output logic                    o_inb2,
  output logic                    o_stanby,
  output logic                    o_vref_pwm,
  output logic signed [POS_W-1:0] o_position,
  output logic                    o_busy,
  output logic                    o_step_strobe
);

  localparam int HT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HT_W-1:0] c_hold = HT_W'(HOLD_CYCLES);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_remaining;
  logic [DIV_W-1:0]        r_period;
  logic [DIV_W-1:0]        r_div;
  logic                    r_dir;
  logic [2:0]              r_idx;
  logic signed [POS_W-1:0] r_position;
  logic                    r_step_strobe;
  logic                    r_step_s1, r_step_s2, r_step_s3;
  logic                    r_dir_s1, r_dir_s2;
  logic [HT_W-1:0]         r_hold;
  logic [PWM_W-1:0]        r_pwm_cnt;
  logic [3:0]              r_coil;
  logic                    r_stanby;
  logic                    r_vref;

  // Coil pattern {A1,A2,B1,B2} for each phase index.
  function automatic logic [3:0] coil_of(input logic [2:0] idx);
    case (idx)
      3'd0:    coil_of = 4'b1000;
      3'd1:    coil_of = 4'b1010;
      3'd2:    coil_of = 4'b0010;
      3'd3:    coil_of = 4'b0110;
      3'd4:    coil_of = 4'b0100;
      3'd5:    coil_of = 4'b0101;
      3'd6:    coil_of = 4'b0001;
      default: coil_of = 4'b1001;
    endcase
  endfunction

  logic                 w_ext_fire, w_run_fire, w_step, w_dir, w_big;
  logic [2:0]           w_delta, w_idx_next;
  logic [DIV_W-1:0]     w_period;
  logic [PWM_W-1:0]     w_level;

  assign o_cmd_ready = (r_state == S_IDLE) && i_module_enable;
  assign o_busy      = (r_state == S_RUN);

  assign w_period   = (i_step_period == '0) ? DIV_W'(1) : i_step_period;
  assign w_ext_fire = r_step_s2 && !r_step_s3 && i_module_enable && (r_state == S_IDLE);
  // Abort has priority over a terminal-count step.
  assign w_run_fire = (r_state == S_RUN) && i_module_enable && !i_abort &&
                      (r_remaining != '0) && (r_div == r_period - DIV_W'(1));
  assign w_step     = w_ext_fire || w_run_fire;
  assign w_dir      = w_run_fire ? r_dir : r_dir_s2;

  // Full mode parks on odd indices, wave mode on even ones; a step from the
  // wrong parity moves by one to realign, otherwise by two.
  assign w_big      = !i_step_mode[1] && (r_idx[0] == (i_step_mode == 2'd1));
  assign w_delta    = w_big ? 3'd2 : 3'd1;
  assign w_idx_next = w_dir ? (r_idx + w_delta) : (r_idx - w_delta);

  assign w_level = (o_busy || (r_hold < c_hold)) ? i_run_level : i_hold_level;

  // External step synchroniser; ext_dir travels alongside so it stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
    end else begin
      r_step_s1 <= i_ext_step;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
      r_dir_s1  <= i_ext_dir;
      r_dir_s2  <= r_dir_s1;
    end
  end

  // Move engine, phase index and position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_period      <= DIV_W'(1);
      r_div         <= '0;
      r_dir         <= 1'b0;
      r_idx         <= 3'd0;
      r_position    <= '0;
      r_step_strobe <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid && i_module_enable) begin
            r_state     <= S_RUN;
            r_remaining <= i_cmd_steps;
            r_dir       <= i_cmd_dir;
            r_period    <= w_period;
            r_div       <= '0;
          end
        end
        S_RUN: begin
          if (i_abort || !i_module_enable || (r_remaining == '0)) begin
            r_state <= S_IDLE;
          end else if (r_div == r_period - DIV_W'(1)) begin
            r_div       <= '0;
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_IDLE;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_step_strobe <= w_step;
      if (w_step) begin
        r_idx      <= w_idx_next;
        r_position <= w_dir ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));
      end
    end
  end

  // Hold timer, PWM and registered driver pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= c_hold;
      r_pwm_cnt <= '0;
      r_coil    <= 4'b0000;
      r_stanby  <= 1'b0;
      r_vref    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (w_step) begin
        r_hold <= '0;
      end else if (r_hold < c_hold) begin
        r_hold <= r_hold + HT_W'(1);
      end
      r_stanby <= i_module_enable;
      r_coil   <= i_module_enable ? coil_of(r_idx) : 4'b0000;
      r_vref   <= i_module_enable && (r_pwm_cnt < w_level);
    end
  end

  assign {o_ina1, o_ina2, o_inb1, o_inb2} = r_coil;
  assign o_stanby      = r_stanby;
  assign o_vref_pwm    = r_vref;
  assign o_position    = r_position;
  assign o_step_strobe = r_step_strobe;

endmodule
`default_nettype wire
